// File: rtl/vert_casc_pkg.sv
// Shared types and sizing for the depth-cascaded 8x4 RAM.
// Address split: top bit picks the bank, low bits pick the word inside it.
package vert_casc_pkg;

    localparam int unsigned DATA_W       = 4;
    localparam int unsigned BANK_AW      = 2;
    localparam int unsigned NUM_BANKS    = 2;
    localparam int unsigned BANK_DEPTH   = 2 ** BANK_AW;
    localparam int unsigned BANK_SEL_BIT = BANK_AW;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [BANK_AW:0]   addr_t;
    typedef logic [BANK_AW-1:0] bank_addr_t;

    function automatic logic bank_of(input addr_t addr);
        return addr[BANK_SEL_BIT];
    endfunction

    function automatic bank_addr_t word_of(input addr_t addr);
        return addr[BANK_AW-1:0];
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One 4-word bank: asynchronous clear, synchronous write, combinational read.
module ram_bank
    import vert_casc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [BANK_AW-1:0] a,
    input  logic [DATA_W-1:0]  d,
    output logic [DATA_W-1:0]  q
);

    word_t mem [BANK_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[a] <= d;
        end
    end

    assign q = mem[a];

endmodule

// File: rtl/vert_casc_ram.sv
// 8x4 single-port RAM from two 4x4 banks stacked in depth.
// Define VERT_CASC_OUT_REG_EN to register Q (one cycle read latency).
module vert_casc_ram
    import vert_casc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               WE,
    input  logic [BANK_AW:0]   A,
    input  logic [DATA_W-1:0]  D,
    output logic [DATA_W-1:0]  Q
);

    logic                 bank_sel;
    logic [BANK_AW-1:0]   word_addr;
    logic                 wr_en;
    logic [NUM_BANKS-1:0] bank_we;
    word_t                bank_q [NUM_BANKS];
    word_t                rd_data;

    assign bank_sel  = bank_of(A);
    assign word_addr = word_of(A);
    // External WE is active-low; banks take an active-high strobe.
    assign wr_en     = ~WE;

    always_comb begin
        bank_we = '0;
        bank_we[bank_sel] = wr_en;
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        ram_bank u_bank (
            .clk (clk),
            .rst (rst),
            .we  (bank_we[i]),
            .a   (word_addr),
            .d   (D),
            .q   (bank_q[i])
        );
    end

    always_comb begin
        rd_data = bank_q[bank_sel];
    end

`ifdef VERT_CASC_OUT_REG_EN
    word_t q_q;

    // Samples the pre-write word, so same-address read-during-write returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= rd_data;
        end
    end

    assign Q = q_q;
`else
    assign Q = rd_data;
`endif

endmodule

// File: tb/tb_vert_casc_ram.sv
// Self-checking bench for vert_casc_ram against an 8-entry array model.
module tb_vert_casc_ram;

    logic       clk;
    logic       rst;
    logic       WE;
    logic [2:0] A;
    logic [3:0] D;
    logic [3:0] Q;

    logic [3:0] model [8];
    logic [3:0] exp_q;
    int         tests;
    int         fails;

    vert_casc_ram dut (
        .clk (clk),
        .rst (rst),
        .WE  (WE),
        .A   (A),
        .D   (D),
        .Q   (Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 4'h0;
        exp_q = 4'h0;
    endtask

    // One access cycle. D first carries d_glitch, then d_v before the edge.
    task automatic op(input logic we_v, input logic [2:0] a_v, input logic [3:0] d_v,
                      input logic [3:0] d_glitch, input string tag);
        @(negedge clk);
        WE = we_v;
        A  = a_v;
        D  = d_glitch;
        #1;
`ifdef VERT_CASC_OUT_REG_EN
        check({tag, "_pre"}, Q, exp_q);
`else
        check({tag, "_pre"}, Q, model[a_v]);
`endif
        #1 D = d_v;
        @(posedge clk);
        exp_q = model[a_v];
        if (!we_v) model[a_v] = d_v;
        #1;
`ifdef VERT_CASC_OUT_REG_EN
        check({tag, "_post"}, Q, exp_q);
`else
        check({tag, "_post"}, Q, model[a_v]);
`endif
    endtask

    // Reset asserted between edges while a write is pending; reset must win.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        WE = 1'b0;
        A  = 3'($urandom_range(0, 7));
        D  = 4'($urandom);
        #2 rst = 1'b1;
        #1;
        clear_model();
        check({tag, "_async"}, Q, 4'h0);
        @(posedge clk);
        #1;
        check({tag, "_held"}, Q, 4'h0);
        @(negedge clk);
        WE = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        WE    = 1'b1;
        A     = 3'd0;
        D     = 4'h0;
        clear_model();
        #12;
        check("reset_q", Q, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) op(1'b1, 3'(i), 4'hF, 4'h5, "rst_read");

        for (int i = 1; i < 8; i++) op(1'b0, 3'(i), 4'(i), 4'(i - 1), "fill_wr");
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 3'(i), 4'h0, 4'h9, "fill_rd");
            check("fill_model", model[i], 4'(i));
        end

        op(1'b0, 3'd3, 4'hA, 4'h1, "iso_wr");
        op(1'b1, 3'd7, 4'h0, 4'h0, "iso_b1");
        op(1'b1, 3'd3, 4'h0, 4'h0, "iso_b0");

        for (int i = 0; i < 3; i++) op(1'b1, 3'd5, 4'hF, 4'hF, "we_hi");

        op(1'b1, 3'd6, 4'h0, 4'h0, "lat_a6");
        op(1'b1, 3'd2, 4'h0, 4'h0, "lat_a2");

        reset_pulse("mid_rst");
        for (int i = 0; i < 8; i++) op(1'b1, 3'(i), 4'h0, 4'h0, "post_rst");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_pulse("rnd_rst");
            end else begin
                op(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 4'($urandom), "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
